// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential signed/unsigned multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width for a given multiplier width; never narrower than one bit.
    function automatic int unsigned f_cnt_w(input int unsigned nb);
        return (nb < 2) ? 1 : $clog2(nb);
    endfunction

    function automatic int unsigned f_prod_w(input int unsigned na, input int unsigned nb);
        return na + nb;
    endfunction

endpackage

// File: rtl/mult_ctrl.sv
// Multiplier sequencer: IDLE/RUN/DONE FSM, bit counter and handshake decode.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned NB_B = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid,
    input  logic i_ready,
    output logic o_ready,
    output logic o_busy,
    output logic o_load,
    output logic o_step,
    output logic o_last_step,
    output logic o_done
);

    localparam int unsigned CNT_W = f_cnt_w(NB_B);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB_B - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_valid)               w_state_nxt = RUN;
            RUN:     if (r_cnt == LAST_CNT)     w_state_nxt = DONE;
            DONE:    if (i_ready)               w_state_nxt = IDLE;
            default:                            w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (o_load)
                r_cnt <= '0;
            else if (o_step)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Handshake outputs decode from registered state only.
    assign o_ready     = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == DONE);
    assign o_step      = (r_state == RUN);
    assign o_last_step = o_step && (r_cnt == LAST_CNT);
    assign o_load      = o_ready && i_valid;

endmodule

// File: rtl/seq_mult_signed.sv
// Shift-add multiplier retiring one multiplier bit per clock, signed or unsigned per operation.
module seq_mult_signed
    import mult_pkg::*;
#(
    parameter int unsigned NB_A = 8,
    parameter int unsigned NB_B = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [NB_A-1:0]                 i_a,
    input  logic [NB_B-1:0]                 i_b,
    input  logic                            i_signed,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [f_prod_w(NB_A, NB_B)-1:0] o_product,
    output logic                            o_busy
);

    logic            w_load;
    logic            w_step;
    logic            w_last_step;
    logic            w_done;

    logic [NB_A-1:0] r_a;
    logic [NB_B-1:0] r_lo;
    logic [NB_A:0]   r_hi;
    logic            r_mode;

    logic [NB_A:0]   w_a_ext;
    logic [NB_A:0]   w_addend;
    logic [NB_A:0]   w_sum;
    logic [NB_A:0]   w_hi_nxt;
    logic [NB_B-1:0] w_lo_nxt;

    mult_ctrl #(
        .NB_B (NB_B)
    ) u_ctrl (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .o_ready     (o_ready),
        .o_busy      (o_busy),
        .o_load      (w_load),
        .o_step      (w_step),
        .o_last_step (w_last_step),
        .o_done      (w_done)
    );

    // The last signed step subtracts: the multiplier MSB carries negative weight.
    assign w_a_ext  = {r_mode & r_a[NB_A-1], r_a};
    assign w_addend = r_lo[0] ? w_a_ext : '0;
    assign w_sum    = (w_last_step && r_mode) ? (r_hi - w_addend) : (r_hi + w_addend);
    assign w_hi_nxt = {r_mode & w_sum[NB_A], w_sum[NB_A:1]};
    assign w_lo_nxt = {w_sum[0], r_lo[NB_B-1:1]};

    // NOTE: the datapath registers are reset because the product output must read zero out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a    <= '0;
            r_lo   <= '0;
            r_hi   <= '0;
            r_mode <= 1'b0;
        end else if (w_load) begin
            r_a    <= i_a;
            r_lo   <= i_b;
            r_hi   <= '0;
            r_mode <= i_signed;
        end else if (w_step) begin
            r_hi   <= w_hi_nxt;
            r_lo   <= w_lo_nxt;
        end
    end

    assign o_valid   = w_done;
    assign o_product = {r_hi[NB_A-1:0], r_lo};

endmodule

// File: tb/tb_seq_mult_signed.sv
// Bench: directed 4x4 cases plus a randomized 8x5 sweep against an integer-arithmetic model.
module tb_seq_mult_signed;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4x4 instance for the directed cases
    logic       v4 = 1'b0, s4 = 1'b0, ir4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       r4, ov4, busy4;
    logic [7:0] p4;

    // 8x5 instance for the random sweep
    logic        v8 = 1'b0, s8 = 1'b0, ir8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [4:0]  b8 = '0;
    logic        r8, ov8, busy8;
    logic [12:0] p8;

    int n_vec = 0;
    int n_err = 0;

    seq_mult_signed #(.NB_A(4), .NB_B(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(r4), .i_a(a4), .i_b(b4),
        .i_signed(s4), .o_valid(ov4), .i_ready(ir4), .o_product(p4), .o_busy(busy4)
    );

    seq_mult_signed #(.NB_A(8), .NB_B(5)) u_dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(r8), .i_a(a8), .i_b(b8),
        .i_signed(s8), .o_valid(ov8), .i_ready(ir8), .o_product(p8), .o_busy(busy8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Exact product reduced to na+nb bits, computed with plain integer arithmetic.
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input bit s, input int na, input int nb);
        longint va = longint'(a);
        longint vb = longint'(b);
        longint p;
        logic [63:0] mask;
        if (s && a[na-1]) va = va - (longint'(1) <<< na);
        if (s && b[nb-1]) vb = vb - (longint'(1) <<< nb);
        p = va * vb;
        mask = (64'd1 << (na + nb)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    task automatic mul4(input logic [3:0] a, input logic [3:0] b, input logic s, input string tag);
        int lat;
        logic [63:0] exp;
        exp = model(64'(a), 64'(b), s, 4, 4);
        check({tag, "_ready"}, 64'(r4), 64'd1);
        v4 = 1'b1; a4 = a; b4 = b; s4 = s; ir4 = 1'b1;
        @(negedge clk);
        v4 = 1'b0;
        lat = 1;
        check({tag, "_busy"}, 64'(busy4), 64'd1);
        while (!ov4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd5);
        check({tag, "_product"}, 64'(p4), exp);
        @(negedge clk);
        check({tag, "_after"}, {62'd0, ov4, r4}, 64'd1);
    endtask

    initial begin
        logic [7:0] held;
        logic       ok;
        int         lat;
        logic [63:0] exp;
        bit          accepted;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_state4", {ov4, busy4, r4, p4}, {1'b0, 1'b0, 1'b1, 8'h00});
        check("reset_state8", {ov8, busy8, r8, p8}, {1'b0, 1'b0, 1'b1, 13'h0});

        mul4(4'hF, 4'hF, 1'b0, "u15x15");
        mul4(4'h8, 4'h8, 1'b1, "s_m8xm8");
        mul4(4'h8, 4'h7, 1'b1, "s_m8x7");
        mul4(4'h7, 4'hF, 1'b1, "s_7xm1");
        mul4(4'hF, 4'hF, 1'b1, "s_m1xm1");
        mul4(4'h0, 4'h9, 1'b1, "s_zero");

        // Back-pressure: product held for 10 cycles, new operands ignored.
        v4 = 1'b1; a4 = 4'hD; b4 = 4'h5; s4 = 1'b1; ir4 = 1'b0;
        @(negedge clk);
        v4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_product", 64'(p4), 64'hF1);
        held = p4;
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            v4 = 1'b1; a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'($urandom);
            @(negedge clk);
            if (!ov4 || r4 || p4 !== held) ok = 1'b0;
        end
        check("bp_hold", 64'(ok), 64'd1);
        v4 = 1'b0; ir4 = 1'b1;
        @(negedge clk);
        check("bp_release", {62'd0, ov4, r4}, 64'd1);

        // Reset in the middle of RUN discards the operation.
        v4 = 1'b1; a4 = 4'hF; b4 = 4'hF; s4 = 1'b0;
        @(negedge clk);
        v4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_run_state", {ov4, busy4, r4, p4}, {1'b0, 1'b0, 1'b1, 8'h00});
        ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ov4 || busy4) ok = 1'b0;
        end
        check("rst_run_no_valid", 64'(ok), 64'd1);
        mul4(4'h3, 4'h5, 1'b0, "u3x5");

        // Random sweep on the 8x5 instance with random consumer back-pressure.
        for (int n = 0; n < 150; n++) begin
            a8 = 8'($urandom);
            b8 = 5'($urandom);
            s8 = 1'($urandom);
            case ($urandom_range(0, 9))
                0: a8 = '0;
                1: b8 = '0;
                default: ;
            endcase
            exp = model(64'(a8), 64'(b8), s8, 8, 5);
            if (!r8) check("rnd_ready", 64'(r8), 64'd1);
            v8 = 1'b1;
            ir8 = 1'($urandom);
            @(negedge clk);
            v8 = 1'b0;
            lat = 1;
            while (!ov8 && lat < 20) begin
                ir8 = 1'($urandom);
                @(negedge clk);
                lat++;
            end
            check("rnd_latency", 64'(lat), 64'd6);
            check("rnd_product", 64'(p8), exp);
            ok = 1'b1;
            accepted = 1'b0;
            for (int k = 0; k < 30 && !accepted; k++) begin
                if (!ov8 || p8 !== exp[12:0]) ok = 1'b0;
                ir8 = (k >= 8) ? 1'b1 : 1'($urandom);
                accepted = ir8;
                @(negedge clk);
            end
            check("rnd_hold", 64'(ok), 64'd1);
            check("rnd_release", {62'd0, ov8, r8}, 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
